// File: rtl/llc_req_scheduler.sv
// llc_req_scheduler: queues CPU and snoop requests and issues them one at a time to the LLC
module llc_req_scheduler #(
  parameter int CPU_DEPTH      = 4,
  parameter int SNP_DEPTH      = 4,
  parameter int MAX_SNP_STREAK = 3,
  parameter int ADDR_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_valid,
  output logic              cpu_ready,
  input  logic [3:0]        cpu_op,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              snp_valid,
  output logic              snp_ready,
  input  logic [3:0]        snp_op,
  input  logic [ADDR_W-1:0] snp_addr,
  output logic              llc_valid,
  input  logic              llc_ready,
  output logic [3:0]        llc_op,
  output logic [ADDR_W-1:0] llc_addr,
  output logic              llc_src,
  input  logic              llc_done,
  output logic              busy,
  output logic [31:0]       cpu_grants,
  output logic [31:0]       snp_grants,
  output logic [15:0]       drop_cnt
);
  localparam int CA = $clog2(CPU_DEPTH);
  localparam int SA = $clog2(SNP_DEPTH);
  localparam int KW = $clog2(MAX_SNP_STREAK + 1);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  state_t state, state_n;
  logic [ADDR_W+3:0] cpu_mem [CPU_DEPTH];
  logic [ADDR_W+3:0] snp_mem [SNP_DEPTH];
  logic [CA:0] cpu_wp, cpu_rp, cpu_wp_n, cpu_rp_n;
  logic [SA:0] snp_wp, snp_rp, snp_wp_n, snp_rp_n;
  logic [ADDR_W+3:0] cpu_head, snp_head;
  logic [KW-1:0] streak;
  logic [16:0] drop_sum;
  logic cpu_legal, snp_legal, cpu_push, snp_push, cpu_drop, snp_drop;
  logic cpu_empty, snp_empty, cpu_full_n, snp_full_n;
  logic cpu_ok, snp_win, gnt_cpu, gnt_snp;
  assign cpu_legal = cpu_op inside {4'd0, 4'd1, 4'd2, 4'd8, 4'd9};
  assign snp_legal = snp_op inside {4'd3, 4'd4, 4'd5, 4'd6};
  assign cpu_push  = cpu_valid && cpu_ready && cpu_legal;
  assign snp_push  = snp_valid && snp_ready && snp_legal;
  assign cpu_drop  = cpu_valid && cpu_ready && !cpu_legal;
  assign snp_drop  = snp_valid && snp_ready && !snp_legal;
  assign cpu_empty = cpu_wp == cpu_rp;
  assign snp_empty = snp_wp == snp_rp;
  assign cpu_head  = cpu_mem[cpu_rp[CA-1:0]];
  assign snp_head  = snp_mem[snp_rp[SA-1:0]];
  // A barrier op at the CPU head yields to every queued snoop, even past the streak limit
  assign cpu_ok    = !cpu_empty && !((cpu_head[ADDR_W+3:ADDR_W] inside {4'd8, 4'd9}) && !snp_empty);
  assign snp_win   = !snp_empty && !(streak == KW'(MAX_SNP_STREAK) && cpu_ok);
  assign gnt_snp   = state == IDLE && snp_win;
  assign gnt_cpu   = state == IDLE && !snp_win && cpu_ok;
  assign cpu_wp_n  = cpu_wp + (CA+1)'(cpu_push);
  assign cpu_rp_n  = cpu_rp + (CA+1)'(gnt_cpu);
  assign snp_wp_n  = snp_wp + (SA+1)'(snp_push);
  assign snp_rp_n  = snp_rp + (SA+1)'(gnt_snp);
  assign cpu_full_n = cpu_wp_n[CA] != cpu_rp_n[CA] && cpu_wp_n[CA-1:0] == cpu_rp_n[CA-1:0];
  assign snp_full_n = snp_wp_n[SA] != snp_rp_n[SA] && snp_wp_n[SA-1:0] == snp_rp_n[SA-1:0];
  assign drop_sum  = {1'b0, drop_cnt} + 17'(cpu_drop) + 17'(snp_drop);
  assign busy      = state != IDLE || !cpu_empty || !snp_empty;
  always_comb begin
    state_n = state;
    state_n = (state == IDLE && (gnt_cpu || gnt_snp)) ? ISSUE :
              (state == ISSUE && llc_ready)            ? WAIT  :
              (state == WAIT && llc_done)              ? IDLE  : state;
  end
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_ff @(posedge clk) begin
    if (cpu_push) cpu_mem[cpu_wp[CA-1:0]] <= {cpu_op, cpu_addr};
    if (snp_push) snp_mem[snp_wp[SA-1:0]] <= {snp_op, snp_addr};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cpu_wp     <= '0;
      cpu_rp     <= '0;
      snp_wp     <= '0;
      snp_rp     <= '0;
      cpu_ready  <= 1'b0;
      snp_ready  <= 1'b0;
      llc_valid  <= 1'b0;
      llc_op     <= '0;
      llc_addr   <= '0;
      llc_src    <= 1'b0;
      streak     <= '0;
      cpu_grants <= '0;
      snp_grants <= '0;
      drop_cnt   <= '0;
    end else begin
      cpu_wp    <= cpu_wp_n;
      cpu_rp    <= cpu_rp_n;
      snp_wp    <= snp_wp_n;
      snp_rp    <= snp_rp_n;
      cpu_ready <= !cpu_full_n;
      snp_ready <= !snp_full_n;
      drop_cnt  <= drop_sum[16] ? '1 : drop_sum[15:0];
      if (gnt_cpu || gnt_snp) begin
        llc_valid <= 1'b1;
        llc_op    <= gnt_snp ? snp_head[ADDR_W+3:ADDR_W] : cpu_head[ADDR_W+3:ADDR_W];
        llc_addr  <= gnt_snp ? snp_head[ADDR_W-1:0] : cpu_head[ADDR_W-1:0];
        llc_src   <= gnt_snp;
      end else if (state == ISSUE && llc_ready) begin
        llc_valid <= 1'b0;
      end
      if (gnt_cpu) streak <= '0;
      else if (gnt_snp) streak <= cpu_empty ? '0 : (streak == KW'(MAX_SNP_STREAK) ? streak : streak + KW'(1));
      if (gnt_cpu && cpu_grants != '1) cpu_grants <= cpu_grants + 32'd1;
      if (gnt_snp && snp_grants != '1) snp_grants <= snp_grants + 32'd1;
    end
  end
endmodule
